// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the external combinational ALU.
// One R-type instruction in flight: IDLE -> DECODE -> EXEC -> WB, with a 32-entry register file and a debug port.
module alu_issue_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OPRN_WIDTH = 6,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [OPRN_WIDTH-1:0] alu_oprn,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  done,
    output logic                  err,
    input  logic                  dbg_we,
    input  logic [REG_ADDR_W-1:0] dbg_waddr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    input  logic [REG_ADDR_W-1:0] dbg_raddr,
    output logic [DATA_WIDTH-1:0] dbg_rdata
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [31:0]             instr_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

    logic [5:0]              opcode;
    logic [REG_ADDR_W-1:0]   rs;
    logic [REG_ADDR_W-1:0]   rt;
    logic [REG_ADDR_W-1:0]   rd;
    logic [4:0]              shamt;
    logic [5:0]              funct;

    logic                    dec_legal;
    logic                    dec_shift;
    logic [OPRN_WIDTH-1:0]   dec_oprn;

    logic                    done_d;
    logic                    err_d;
    logic                    ready_d;
    logic                    op_load;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];

    // funct to ALU operation code; anything unmapped or with a nonzero opcode is illegal
    always_comb begin
        dec_legal = 1'b1;
        dec_shift = 1'b0;
        dec_oprn  = '0;
        case (funct)
            6'h20: dec_oprn = OPRN_WIDTH'(8'h01);
            6'h22: dec_oprn = OPRN_WIDTH'(8'h02);
            6'h2C: dec_oprn = OPRN_WIDTH'(8'h03);
            6'h02: begin dec_oprn = OPRN_WIDTH'(8'h04); dec_shift = 1'b1; end
            6'h01: begin dec_oprn = OPRN_WIDTH'(8'h05); dec_shift = 1'b1; end
            6'h24: dec_oprn = OPRN_WIDTH'(8'h06);
            6'h25: dec_oprn = OPRN_WIDTH'(8'h07);
            6'h27: dec_oprn = OPRN_WIDTH'(8'h08);
            6'h2A: dec_oprn = OPRN_WIDTH'(8'h09);
            default: dec_legal = 1'b0;
        endcase
        if (opcode != 6'd0) dec_legal = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (instr_valid) next_state = S_DECODE;
            S_DECODE: next_state = dec_legal ? S_EXEC : S_IDLE;
            S_EXEC:   next_state = S_WB;
            S_WB:     next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        op_load = 1'b0;
        ready_d = (next_state == S_IDLE);
        case (state)
            S_DECODE: begin
                err_d   = !dec_legal;
                op_load = dec_legal;
            end
            S_WB:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            instr_ready <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
            alu_op1     <= '0;
            alu_op2     <= '0;
            alu_oprn    <= '0;
            instr_q     <= '0;
            result_q    <= '0;
        end else begin
            instr_ready <= ready_d;
            done        <= done_d;
            err         <= err_d;
            if (state == S_IDLE && instr_valid) instr_q <= instr;
            if (state == S_EXEC) result_q <= alu_result;
            if (op_load) begin
                alu_op1  <= regs[rs];
                alu_op2  <= dec_shift ? DATA_WIDTH'(shamt) : regs[rt];
                alu_oprn <= dec_oprn;
            end
        end
    end

    // R0 is never written, so it stays at its reset value of zero
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
        end else begin
            if (state == S_IDLE && dbg_we && dbg_waddr != '0) regs[dbg_waddr] <= dbg_wdata;
            if (state == S_WB && rd != '0) regs[rd] <= result_q;
        end
    end

    assign dbg_rdata = regs[dbg_raddr];

endmodule
